// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: memory-controller PC handshake plus the decoder-facing queue head.
interface inst_fetch_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32
);
  logic                  if_get_pc;
  logic [ADDR_WIDTH-1:0] pc_get;
  logic                  if_out_inst_to_pc;
  logic [INST_WIDTH-1:0] inst_out_to_pc;
  logic                  if_inst_valid;
  logic [INST_WIDTH-1:0] inst_out;
  logic [ADDR_WIDTH-1:0] inst_pc_out;
  logic                  inst_pred_jump;
  logic [ADDR_WIDTH-1:0] inst_pred_pc;
  logic                  decoder_ready;

  modport master (
    output if_get_pc, pc_get, if_inst_valid, inst_out, inst_pc_out, inst_pred_jump, inst_pred_pc,
    input  if_out_inst_to_pc, inst_out_to_pc, decoder_ready
  );

  modport slave (
    input  if_get_pc, pc_get, if_inst_valid, inst_out, inst_pc_out, inst_pred_jump, inst_pred_pc,
    output if_out_inst_to_pc, inst_out_to_pc, decoder_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding PC request, static next-PC prediction,
// and a small queue of {pc, inst, prediction} entries drained by the decoder.
module inst_fetch #(
  parameter int unsigned QUEUE_DEPTH = 8,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INST_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] clear_pc,
  inst_fetch_if.master          bus
);
  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
    logic                  jump;
    logic [ADDR_WIDTH-1:0] target;
  } entry_t;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_get_q;
  logic                  if_get_pc_q;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  entry_t                queue [QUEUE_DEPTH];

  logic [INST_WIDTH-1:0] instr_c;
  logic [ADDR_WIDTH-1:0] j_imm_c;
  logic [ADDR_WIDTH-1:0] b_imm_c;
  logic                  pred_jump_c;
  logic [ADDR_WIDTH-1:0] pred_pc_c;
  logic                  push_c;
  logic                  pop_c;
  entry_t                head_c;

  assign instr_c = bus.inst_out_to_pc;
  assign j_imm_c = {{(ADDR_WIDTH-21){instr_c[31]}}, instr_c[31], instr_c[19:12],
                    instr_c[20], instr_c[30:21], 1'b0};
  assign b_imm_c = {{(ADDR_WIDTH-13){instr_c[31]}}, instr_c[31], instr_c[7],
                    instr_c[30:25], instr_c[11:8], 1'b0};

  // Static prediction: JAL and backward branches taken, everything else falls through.
  always_comb begin
    pred_jump_c = 1'b0;
    pred_pc_c   = pc + ADDR_WIDTH'(4);
    if (instr_c[6:0] == OP_JAL) begin
      pred_jump_c = 1'b1;
      pred_pc_c   = pc + j_imm_c;
    end else if (instr_c[6:0] == OP_BRANCH && instr_c[31]) begin
      pred_jump_c = 1'b1;
      pred_pc_c   = pc + b_imm_c;
    end
  end

  assign push_c = (state == FETCH) && bus.if_out_inst_to_pc;
  assign pop_c  = (count != '0) && bus.decoder_ready;

  // Entry storage needs no reset; the empty flag gates every head output.
  always_ff @(posedge clk) begin
    if (rdy && !clear && push_c) begin
      queue[tail] <= '{pc: pc, inst: instr_c, jump: pred_jump_c, target: pred_pc_c};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= '0;
      pc_get_q    <= '0;
      if_get_pc_q <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (rdy) begin
      if (clear) begin
        state       <= IDLE;
        pc          <= clear_pc;
        if_get_pc_q <= 1'b0;
        head        <= '0;
        tail        <= '0;
        count       <= '0;
      end else begin
        head  <= head + PTR_W'(pop_c);
        tail  <= tail + PTR_W'(push_c);
        count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
        case (state)
          IDLE: begin
            if (count < CNT_W'(QUEUE_DEPTH)) begin
              pc_get_q    <= pc;
              if_get_pc_q <= 1'b1;
              state       <= FETCH;
            end
          end
          FETCH: begin
            if (push_c) begin
              pc          <= pred_pc_c;
              if_get_pc_q <= 1'b0;
              state       <= HOLD;
            end
          end
          // pc_get stays on the old PC for one cycle so the icache fill lands correctly.
          HOLD:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign head_c = (count != '0) ? queue[head] : '0;

  assign bus.if_get_pc      = if_get_pc_q;
  assign bus.pc_get         = pc_get_q;
  assign bus.if_inst_valid  = (count != '0);
  assign bus.inst_out       = head_c.inst;
  assign bus.inst_pc_out    = head_c.pc;
  assign bus.inst_pred_jump = head_c.jump;
  assign bus.inst_pred_pc   = head_c.target;
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Front-end fetch stage directly upstream of the memory controller's PC port.
- Holds the PC and issues one instruction request at a time over the if_get_pc/pc_get handshake, which serves hits from the controller's icache or falls through to a 4-byte RAM read.
- Applies static next-PC prediction and buffers fetched {pc, inst, prediction} entries in a FIFO that the decoder drains.
- On clear (mispredict or flush) it discards all in-flight and queued work and restarts at clear_pc.

Parameters:
QUEUE_DEPTH, 8, instruction queue entries (power of 2, ≥2)
ADDR_WIDTH, 32, PC width
INST_WIDTH, 32, instruction width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-low
rdy  input  1  global ready; when low all state frozen, outputs held
clear  input  1  flush/redirect pulse from ROB
clear_pc  input  ADDR_WIDTH  restart PC, valid with clear
if_get_pc  output  1  fetch request to memory controller
pc_get  output  ADDR_WIDTH  fetch address to memory controller
if_out_inst_to_pc  input  1  controller returns instruction (1-cycle pulse)
inst_out_to_pc  input  INST_WIDTH  returned instruction word
if_inst_valid  output  1  queue head valid to decoder
inst_out  output  INST_WIDTH  queue head instruction
inst_pc_out  output  ADDR_WIDTH  queue head PC
inst_pred_jump  output  1  head was predicted taken
inst_pred_pc  output  ADDR_WIDTH  head predicted next PC
decoder_ready  input  1  decoder pops head this cycle

Behaviour:
- Reset (rst=0, async): pc=0, state IDLE, queue empty (head=tail=0, count=0), if_get_pc=0, pc_get=0, all queue outputs read as 0 with if_inst_valid=0.
- FSM: IDLE, FETCH, HOLD.
- IDLE: if count < QUEUE_DEPTH, drive pc_get=pc and if_get_pc=1, then go to FETCH. Otherwise stay in IDLE with if_get_pc=0.
- FETCH: hold if_get_pc=1 and keep pc_get stable until if_out_inst_to_pc=1. In that cycle:
  - push {pc, inst_out_to_pc, pred_jump, pred_pc} at tail;
  - pc <= pred_pc;
  - go to HOLD.
- HOLD: exactly one cycle with if_get_pc=0 and pc_get still the old PC, so the controller's icache fill indexes the correct address. Then go to IDLE, which drives the new PC on the next cycle.
- Fetch latency:
  - hit: request cycle → response next cycle (2 cycles + 1 HOLD + 1 IDLE per instruction);
  - miss: response at controller stage 5.
- A slot is reserved at issue. Count is checked in IDLE and only decreases while waiting, so a push never overflows.
- Prediction, computed combinationally on inst_out_to_pc:
  - opcode 1101111 (JAL): pred_jump=1, pred_pc = pc + sign-extended J-immediate {i[31], i[19:12], i[20], i[30:21], 0}.
  - opcode 1100011 (branch) with i[31]=1 (backward): pred_jump=1, pred_pc = pc + B-immediate {i[31], i[7], i[30:25], i[11:8], 0}.
  - All others, including JALR and forward branches: pred_jump=0, pred_pc = pc+4.
  - All adds are modulo 2^ADDR_WIDTH.
- Queue:
  - if_inst_valid = (count != 0); head fields are presented combinationally.
  - Pop when if_inst_valid && decoder_ready.
  - Simultaneous push and pop is allowed: count unchanged, both pointers advance.
  - Pointers wrap modulo QUEUE_DEPTH.
  - Pop on an empty queue is ignored.
- clear (synchronous, with rdy=1), taking priority over everything:
  - queue emptied; pc <= clear_pc; state IDLE; if_get_pc <= 0;
  - any if_out_inst_to_pc arriving in the same cycle is discarded;
  - the first request of clear_pc appears on the cycle after clear.
- rdy=0: no state change; inputs arriving that cycle are ignored, including a response pulse. The controller is frozen by the same rdy.
- Async rst asserted mid-fetch: immediate return to reset values; the pending response is never pushed.

Test Plan:
- Reset, then release; controller returns 0x00000013 at pc 0 as a hit → pc_get=0 in cycle 1, push {pc=0, inst=0x13, pred=0, pred_pc=4}, HOLD shows pc_get=0 with if_get_pc=0, next request pc_get=4.
- JAL 0x0100006F fetched at pc 0x20 → pred_jump=1, pred_pc=0x30, next pc_get=0x30.
- Backward branch 0xFE000EE3 at pc 0x40 → pred_pc=0x3C with pred_jump=1; forward branch 0x00000463 → pred_pc=0x44 with pred_jump=0.
- Decoder_ready=0 with 8 responses delivered → count=8, if_get_pc stays 0 in IDLE. Then one pop → new request issues, and pointer wrap is checked.
- clear=1, clear_pc=0x1000 in the same cycle as if_out_inst_to_pc, with 3 queued entries → queue empty, no push, next pc_get=0x1000.
- rdy=0 for 3 cycles mid-FETCH → pc_get, if_get_pc and queue unchanged. Resume → normal completion.
